// File: rtl/ex_if.sv
// EX-stage bus bundle: ID/EX instruction slot, forwarding sources, EX/MEM slot,
// redirect and status outputs. slave = execute stage, master = its environment.
interface ex_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic             use_imm;
    logic             set_cc;
    logic             is_br;
    logic [2:0]       br_nzp;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] sr1_out;
    logic [WIDTH-1:0] sr2_out;
    logic [WIDTH-1:0] sext_value;
    logic [2:0]       sr1;
    logic [2:0]       sr2;
    logic [2:0]       dr;
    logic             pred;
    logic             btb_hit;
    logic             fwd_mem_en;
    logic             fwd_wb_en;
    logic [2:0]       fwd_mem_reg;
    logic [2:0]       fwd_wb_reg;
    logic [WIDTH-1:0] fwd_mem_val;
    logic [WIDTH-1:0] fwd_wb_val;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_pc;
    logic [2:0]       out_dr;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [2:0]       cc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport slave (
        input  in_valid, alu_op, use_imm, set_cc, is_br, br_nzp, pc,
               sr1_out, sr2_out, sext_value, sr1, sr2, dr, pred, btb_hit,
               fwd_mem_en, fwd_wb_en, fwd_mem_reg, fwd_wb_reg,
               fwd_mem_val, fwd_wb_val, out_ready,
        output in_ready, out_valid, out_result, out_pc, out_dr,
               redirect, redirect_pc, cc, br_count, mispred_count
    );

    modport master (
        output in_valid, alu_op, use_imm, set_cc, is_br, br_nzp, pc,
               sr1_out, sr2_out, sext_value, sr1, sr2, dr, pred, btb_hit,
               fwd_mem_en, fwd_wb_en, fwd_mem_reg, fwd_wb_reg,
               fwd_mem_val, fwd_wb_val, out_ready,
        input  in_ready, out_valid, out_result, out_pc, out_dr,
               redirect, redirect_pc, cc, br_count, mispred_count
    );
endinterface

// File: rtl/ex_stage.sv
// LC-3b execute stage: forwarding, ALU, branch resolution, NZP and EX/MEM slot.
// Define KXL_EX_MUL_EN to make alu_op 8 a 16-cycle shift-add multiply.
module ex_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input logic clk,
    input logic reset,
    ex_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_NOT   = 4'd2;
    localparam logic [3:0] OP_PASSB = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SRA   = 4'd6;
    localparam logic [3:0] OP_ADDR  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam int unsigned MUL_STEPS = 16;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_pc;
    logic [2:0]       out_dr;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [2:0]       cc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    logic [WIDTH-1:0] op_a, sr2_fwd, op_b, result;
    logic             slot_free, in_ready, accept, mul_start, single, mul_load;
    logic             taken, predicted;
    logic [WIDTH-1:0] mul_product;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v == '0, !v[WIDTH-1] && (v != '0)};
    endfunction

    // MEM beats WB; either needs its enable and a matching index
    always_comb begin
        op_a = bus.sr1_out;
        if (bus.fwd_mem_en && bus.fwd_mem_reg == bus.sr1)     op_a = bus.fwd_mem_val;
        else if (bus.fwd_wb_en && bus.fwd_wb_reg == bus.sr1)  op_a = bus.fwd_wb_val;
        sr2_fwd = bus.sr2_out;
        if (bus.fwd_mem_en && bus.fwd_mem_reg == bus.sr2)     sr2_fwd = bus.fwd_mem_val;
        else if (bus.fwd_wb_en && bus.fwd_wb_reg == bus.sr2)  sr2_fwd = bus.fwd_wb_val;
        op_b = bus.use_imm ? bus.sext_value : sr2_fwd;
    end

    always_comb begin
        result = '0;
        case (bus.alu_op)
            OP_ADD:   result = op_a + op_b;
            OP_AND:   result = op_a & op_b;
            OP_NOT:   result = ~op_a;
            OP_PASSB: result = op_b;
            OP_SLL:   result = op_a << op_b[3:0];
            OP_SRL:   result = op_a >> op_b[3:0];
            OP_SRA:   result = WIDTH'($signed(op_a) >>> op_b[3:0]);
            OP_ADDR:  result = bus.pc + bus.sext_value;
            OP_MUL:   result = op_b;
            default:  result = '0;
        endcase
    end

    // A redirect cycle squashes whatever ID/EX is presenting (wrong path)
    assign slot_free = !out_valid || bus.out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = bus.in_valid && in_ready && !redirect;
    assign taken     = |(bus.br_nzp & cc);
    assign predicted = bus.pred && bus.btb_hit;

`ifdef KXL_EX_MUL_EN
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [4:0]       step;
    logic [WIDTH-1:0] m_pc;
    logic [2:0]       m_dr;
    logic             m_set_cc;

    // step==16 means the product is complete and waiting for the slot
    assign mul_start   = accept && (bus.alu_op == OP_MUL);
    assign mul_product = (step == 5'(MUL_STEPS)) ? acc : acc + (mplier[0] ? mcand : '0);
    assign mul_load    = (state == MUL) && (step >= 5'(MUL_STEPS - 1)) && slot_free;
`else
    assign mul_start   = 1'b0;
    assign mul_product = '0;
    assign mul_load    = 1'b0;
`endif
    assign single = accept && !mul_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_pc        <= '0;
            out_dr        <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            cc            <= 3'b010;
            br_count      <= '0;
            mispred_count <= '0;
`ifdef KXL_EX_MUL_EN
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            step     <= '0;
            m_pc     <= '0;
            m_dr     <= '0;
            m_set_cc <= 1'b0;
`endif
        end else begin
            redirect <= 1'b0;
            if (accept && bus.is_br) begin
                if (br_count != '1) br_count <= br_count + 1'b1;
                if (taken != predicted) begin
                    redirect    <= 1'b1;
                    redirect_pc <= taken ? bus.pc + bus.sext_value : bus.pc;
                    if (mispred_count != '1) mispred_count <= mispred_count + 1'b1;
                end
            end

            if (single) begin
                out_valid  <= 1'b1;
                out_result <= result;
                out_pc     <= bus.pc;
                out_dr     <= bus.dr;
                if (bus.set_cc) cc <= nzp_of(result);
`ifdef KXL_EX_MUL_EN
            end else if (mul_load) begin
                out_valid  <= 1'b1;
                out_result <= mul_product;
                out_pc     <= m_pc;
                out_dr     <= m_dr;
                if (m_set_cc) cc <= nzp_of(mul_product);
`endif
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end

`ifdef KXL_EX_MUL_EN
            case (state)
                IDLE: if (mul_start) begin
                    state    <= MUL;
                    mcand    <= op_a;
                    mplier   <= op_b;
                    acc      <= '0;
                    step     <= '0;
                    m_pc     <= bus.pc;
                    m_dr     <= bus.dr;
                    m_set_cc <= bus.set_cc;
                end
                MUL: begin
                    if (step != 5'(MUL_STEPS)) begin
                        acc    <= mul_product;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        step   <= step + 1'b1;
                    end
                    if (mul_load) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_result    = out_result;
    assign bus.out_pc        = out_pc;
    assign bus.out_dr        = out_dr;
    assign bus.redirect      = redirect;
    assign bus.redirect_pc   = redirect_pc;
    assign bus.cc            = cc;
    assign bus.br_count      = br_count;
    assign bus.mispred_count = mispred_count;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the LC-3b pipeline; consumes the decoded instruction held in the ID/EX pipeline register.
- Performs ALU/address arithmetic with operand forwarding.
- Resolves conditional branches against the prediction carried down from fetch, and owns the NZP condition-code register.
- Registers results into an EX/MEM output slot with a valid/ready handshake toward MEM.

Parameters:
- WIDTH, 16, datapath width in bits.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ID/EX slot holds a real instruction
- in_ready  out  1  EX accepts the instruction this cycle; ID/EX loads on this
- alu_op  in  4  0 ADD, 1 AND, 2 NOT, 3 PASSB, 4 SLL, 5 SRL, 6 SRA, 7 ADDR (pc+sext), 8 MUL
- use_imm  in  1  operand B = sext_value, else sr2 value
- set_cc  in  1  update NZP from result
- is_br  in  1  conditional branch
- br_nzp  in  3  branch condition mask
- pc  in  WIDTH  incremented PC of the instruction
- sr1_out, sr2_out, sext_value  in  WIDTH  operands
- sr1, sr2, dr  in  3  register indices
- pred, btb_hit  in  1  fetch prediction
- fwd_mem_en, fwd_wb_en  in  1  forward sources valid
- fwd_mem_reg, fwd_wb_reg  in  3  forward destination indices
- fwd_mem_val, fwd_wb_val  in  WIDTH  forward data
- out_valid  out  1  EX/MEM slot valid
- out_ready  in  1  MEM consumes slot
- out_result, out_pc  out  WIDTH  registered result, pc
- out_dr  out  3  registered destination
- redirect  out  1  one-cycle mispredict pulse; also the flush for IF/ID and ID/EX
- redirect_pc  out  WIDTH  correct fetch address
- cc  out  3  current NZP
- br_count, mispred_count  out  CNT_W  performance counters

Behaviour:
- Reset (asynchronous, any state, including mid-multiply):
  - out_valid=0; out_result, out_pc, out_dr=0
  - redirect=0; redirect_pc=0
  - cc=3'b010 (Z)
  - counters=0
  - FSM → IDLE
- Forwarding, per source operand:
  - MEM wins over WB when both match.
  - Match requires the enable bit and an equal index.
  - Otherwise the ID/EX value is used.
- Operand B = use_imm ? sext_value : forwarded sr2.
- Shift amount = B[3:0].
- All arithmetic is modulo 2^WIDTH.
- SRA replicates bit WIDTH-1.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept (single-cycle ops):
  - out_valid←1; output slot loads result, pc, dr.
  - If set_cc: cc←{result[15], result==0, !result[15] && result!=0}.
- When out_valid && out_ready && no accept: out_valid←0.
- Holding: while !out_ready, the output slot is stable.
- Branch resolution on accepted is_br:
  - taken = |(br_nzp & cc), using the cc value before this cycle's update.
  - predicted = pred && btb_hit.
  - taken && !predicted → redirect=1, redirect_pc=pc+sext_value.
  - !taken && predicted → redirect=1, redirect_pc=pc.
  - Otherwise redirect=0.
  - redirect is registered: it asserts the cycle after accept, for exactly one cycle.
- Flush: during a redirect cycle, any in_valid from ID/EX is ignored (not accepted) because it is wrong-path.
- Counters:
  - br_count increments on each accepted is_br.
  - mispred_count increments on each redirect.
  - Both saturate at all-ones.
- in_valid=0: no state change except draining the output slot.

Optional Feature:
- Macro: KXL_EX_MUL_EN.
- Defined: alu_op 8 runs a shift-add multiplier.
  - FSM IDLE→MUL on accept; an internal 5-bit counter runs 16 cycles.
  - in_ready=0 while in MUL.
  - At count 16: if the output slot is free, load the low WIDTH bits of the product into it, set cc if set_cc, return to IDLE. Otherwise wait in MUL.
  - Operands are captured at accept; forwarding changes afterwards have no effect.
- Undefined: alu_op 8 behaves as PASSB; the FSM never leaves IDLE.

Test Plan:
- Reset released; ADD, sr1_out=0x0005, sr2_out=0x0003, out_ready=1 → next cycle out_valid=1, out_result=0x0008; set_cc gives cc=001.
- ADD, sr1=2, sr1_out=0x1111, fwd_mem_en=1, fwd_mem_reg=2, fwd_mem_val=0x0100, fwd_wb same reg with 0x0200, sext_value=1, use_imm=1 → out_result=0x0101.
- out_ready=0 with slot full → in_ready=0, outputs held for 3 cycles; out_ready=1 → slot drains, next instruction accepted.
- cc=100, BR n, pred=0, pc=0x3002, sext_value=0x0010 → redirect=1 for one cycle, redirect_pc=0x3012; br_count=1, mispred_count=1.
- cc=010, BR p, pred=1, btb_hit=1, pc=0x3002 → redirect_pc=0x3002. Same with pred=1, btb_hit=0 → no redirect.
- With KXL_EX_MUL_EN: MUL 0x0007×0x0006 → in_ready=0 for 16 cycles, then out_result=0x002A. Assert reset at cycle 8 → out_valid=0, FSM IDLE, in_ready=1 after release.
